imm_ext_arbiter: RTL and testbench



---
 rtl/imm_ext_arbiter.sv | 111 +++++++++++
 tb/tb_imm_ext_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_arbiter.sv
// Shared 16->32 immediate-extension unit: two-requester round-robin arbiter
// feeding a single valid/ready output register.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_EMPTY | output register holds no result (out_valid = 0)
// ST_FULL  | output register holds a result awaiting out_ready
module imm_ext_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [15:0] req0_imm,
    input  logic [1:0]  req0_mode,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_imm,
    input  logic [1:0]  req1_mode,
    output logic        req1_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_id,
    input  logic        out_ready
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_out_data;
    logic        r_out_id;
    logic        r_last_grant;

    logic        w_load;
    logic        w_any_valid;
    logic        w_grant_id;
    logic        w_grant;
    logic [15:0] w_sel_imm;
    logic [1:0]  w_sel_mode;
    logic [31:0] w_ext;

    function automatic logic [31:0] f_extend(input logic [15:0] imm, input logic [1:0] mode);
        logic [31:0] v_res;
        case (mode)
            2'b00:   v_res = {16'h0000, imm};
            2'b01:   v_res = {{16{imm[15]}}, imm};
            2'b10:   v_res = {imm, 16'h0000};
            default: v_res = {{14{imm[15]}}, imm, 2'b00};
        endcase
        return v_res;
    endfunction

    // rst_n gates load so neither ready can rise while reset is held.
    assign w_load      = rst_n && ((r_state == ST_EMPTY) || out_ready);
    assign w_any_valid = req0_valid || req1_valid;

    always_comb begin
        w_grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_id = ~r_last_grant;
        end else begin
            w_grant_id = req1_valid;
        end
    end

    assign w_grant    = w_load && w_any_valid;
    assign req0_ready = w_grant && !w_grant_id;
    assign req1_ready = w_grant && w_grant_id;

    assign w_sel_imm  = w_grant_id ? req1_imm  : req0_imm;
    assign w_sel_mode = w_grant_id ? req1_mode : req0_mode;
    assign w_ext      = f_extend(w_sel_imm, w_sel_mode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_out_data   <= 32'h0;
            r_out_id     <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_grant) begin
                        r_state      <= ST_FULL;
                        r_out_data   <= w_ext;
                        r_out_id     <= w_grant_id;
                        r_last_grant <= w_grant_id;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (w_grant) begin
                            r_out_data   <= w_ext;
                            r_out_id     <= w_grant_id;
                            r_last_grant <= w_grant_id;
                        end else begin
                            r_state <= ST_EMPTY;
                        end
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Self-checking bench for imm_ext_arbiter: directed scenarios followed by a
// randomized phase, all compared against a transaction-level model.
module tb_imm_ext_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [15:0] req0_imm;
    logic [1:0]  req0_mode;
    logic        req0_ready;
    logic        req1_valid;
    logic [15:0] req1_imm;
    logic [1:0]  req1_mode;
    logic        req1_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_id;
    logic        out_ready;

    int n_checks = 0;
    int n_errors = 0;

    // model state: what the output register should hold
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_id;
    logic        m_last;
    logic        acc0, acc1;

    imm_ext_arbiter u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_imm   (req0_imm),
        .req0_mode  (req0_mode),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_imm   (req1_imm),
        .req1_mode  (req1_mode),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
        int s;
        s = $signed(imm);
        case (mode)
            2'd0:    return 32'(imm);
            2'd1:    return 32'(s);
            2'd2:    return 32'(imm) * 32'd65536;
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 32'h0;
        m_id    = 1'b0;
        m_last  = 1'b1;
    endtask

    // One clock: check readies mid-cycle, advance model at the edge, check outputs after it.
    task automatic cycle();
        logic e_load, e_g0, e_g1;
        @(negedge clk);
        e_load = !m_valid || out_ready;
        if (req0_valid && req1_valid) begin
            e_g0 = (m_last == 1'b1);
            e_g1 = !e_g0;
        end else begin
            e_g0 = req0_valid;
            e_g1 = req1_valid;
        end
        e_g0 = e_g0 && e_load;
        e_g1 = e_g1 && e_load;
        chk("ready0", 32'(req0_ready), 32'(e_g0));
        chk("ready1", 32'(req1_ready), 32'(e_g1));
        @(posedge clk);
        if (e_g0) begin
            m_valid = 1'b1; m_data = ref_ext(req0_imm, req0_mode); m_id = 1'b0; m_last = 1'b0;
        end else if (e_g1) begin
            m_valid = 1'b1; m_data = ref_ext(req1_imm, req1_mode); m_id = 1'b1; m_last = 1'b1;
        end else if (e_load) begin
            m_valid = 1'b0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", out_data, m_data);
        chk("out_id", 32'(out_id), 32'(m_id));
        acc0 = e_g0;
        acc1 = e_g1;
    endtask

    logic [31:0] k_modes [4];
    logic [31:0] held_data;
    logic        held_id;

    initial begin
        k_modes[0] = 32'h00008001;
        k_modes[1] = 32'hFFFF8001;
        k_modes[2] = 32'h80010000;
        k_modes[3] = 32'hFFFE0004;

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_imm = 16'h1234; req0_mode = 2'd0;
        req1_valid = 1'b1; req1_imm = 16'h5678; req1_mode = 2'd1;
        out_ready = 1'b1;
        model_reset();
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_id", 32'(out_id), 32'h0);
        chk("rst_ready0", 32'(req0_ready), 32'h0);
        chk("rst_ready1", 32'(req1_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;

        // all four modes on requester 0
        for (int m = 0; m < 4; m++) begin
            req0_valid = 1'b1; req0_imm = 16'h8001; req0_mode = 2'(m);
            cycle();
            chk("mode_acc", 32'(acc0), 32'h1);
            chk("mode_data", out_data, k_modes[m]);
        end
        req0_valid = 1'b0;

        req1_valid = 1'b1; req1_imm = 16'h0004; req1_mode = 2'd3;
        cycle();
        chk("pos_off_data", out_data, 32'h00000010);
        chk("pos_off_id", 32'(out_id), 32'h1);

        // drain
        req1_valid = 1'b0;
        cycle();
        chk("drain_valid", 32'(out_valid), 32'h0);
        chk("drain_keep_data", out_data, 32'h00000010);

        // contention after a mid-stream reset
        req0_valid = 1'b1; req0_imm = 16'hABCD; req0_mode = 2'd1;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_data", out_data, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_imm = 16'h0011; req0_mode = 2'd0;
        req1_valid = 1'b1; req1_imm = 16'h0022; req1_mode = 2'd2;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("contend_id", 32'(out_id), 32'(i % 2));
        end

        // backpressure: hold 3 cycles then resume without a bubble
        held_data = out_data;
        held_id   = out_id;
        out_ready = 1'b0;
        repeat (3) begin
            cycle();
            chk("bp_hold_data", out_data, held_data);
            chk("bp_hold_id", 32'(out_id), 32'(held_id));
            chk("bp_no_ready", 32'({req0_ready, req1_ready}), 32'h0);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_resume_valid", 32'(out_valid), 32'h1);
        chk("bp_resume_id", 32'(out_id), 32'(!held_id));

        // randomized traffic; requesters hold their request until accepted
        for (int i = 0; i < 400; i++) begin
            if (acc0 || !req0_valid) begin
                req0_valid = ($urandom_range(3) != 0);
                req0_imm   = 16'($urandom);
                req0_mode  = 2'($urandom);
            end
            if (acc1 || !req1_valid) begin
                req1_valid = ($urandom_range(3) != 0);
                req1_imm   = 16'($urandom);
                req1_mode  = 2'($urandom);
            end
            out_ready = ($urandom_range(9) < 7);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
